// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_e;

    localparam int   DATA_BITS            = 8;
    localparam logic IDLE_LEVEL           = 1'b1;
    localparam int   DEFAULT_CLKS_PER_BIT = 2604;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability flop chain for the asynchronous serial line; resets to the idle level.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic sys_rstn,
    input  logic rxd_i,
    output logic rxs_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            always_ff @(posedge clk_in or negedge sys_rstn) begin
                if (!sys_rstn) sync_q[0] <= IDLE_LEVEL;
                else           sync_q[0] <= rxd_i;
            end
        end else begin : g_next
            always_ff @(posedge clk_in or negedge sys_rstn) begin
                if (!sys_rstn) sync_q[gi] <= IDLE_LEVEL;
                else           sync_q[gi] <= sync_q[gi-1];
            end
        end
    end

    assign rxs_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: 8N1 framing, one-entry holding register with valid/ready, sticky errors.
// Define UART_RX_PARITY_EN to add a parity bit (parity_odd input, parity_err output).
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk_in,
    input  logic                 sys_rstn,
    input  logic                 uart_rxd,
    input  logic                 rx_ready,
    input  logic                 err_clr,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
    output logic                 parity_err,
`endif
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

    logic                 rxs;
    rx_state_e            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 busy_q;
    logic                 byte_ok;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_in  (clk_in),
        .sys_rstn(sys_rstn),
        .rxd_i   (uart_rxd),
        .rxs_o   (rxs)
    );

    assign cnt_d = cnt_q + 1'b1;

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;
    logic par_bad_q;
    assign byte_ok    = ~par_bad_q;
    assign parity_err = parity_err_q;
`else
    assign byte_ok = 1'b1;
`endif

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
            par_bad_q    <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_d;
            if (valid_q && rx_ready) valid_q <= 1'b0;
            // Clears come first so that an error event later in this block wins.
            if (err_clr) begin
                frame_err_q <= 1'b0;
                overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= 1'b0;
`endif
            end

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (rxs != IDLE_LEVEL) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_q <= '0;
                        if (rxs != IDLE_LEVEL) begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                            par_bad_q <= 1'b0;
`endif
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q              <= '0;
                        shift_q[bit_idx_q] <= rxs;
                        bit_idx_q          <= bit_idx_q + 1'b1;
                        if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q   <= '0;
                        state_q <= STOP;
                        if (rxs != (^shift_q ^ parity_odd)) begin
                            parity_err_q <= 1'b1;
                            par_bad_q    <= 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q <= '0;
                        if (rxs) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            // A same-cycle consume frees the slot for the new byte.
                            if (byte_ok) begin
                                if (!valid_q || rx_ready) begin
                                    data_q  <= shift_q;
                                    valid_q <= 1'b1;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    cnt_q <= '0;
                    if (rxs) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
    assign rx_busy     = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 16 clocks per bit; one line per checked transaction.
module tb_uart_rx_frame;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Clock edges from driving the start bit until the mid-stop sample:
    // 2 sync + 1 detect + half bit (8) + one full bit per data/parity bit + one for stop.
    localparam int STOP_SAMPLE = 3 + CPB / 2 + (NBITS - 1) * CPB;

    logic       clk_in = 1'b0;
    logic       sys_rstn;
    logic       uart_rxd;
    logic       rx_ready;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun_err;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_odd;
    logic       parity_err;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int start_cyc;
    int rise_cyc;
    logic valid_prev = 1'b0;

    uart_rx_frame #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk_in     (clk_in),
        .sys_rstn   (sys_rstn),
        .uart_rxd   (uart_rxd),
        .rx_ready   (rx_ready),
        .err_clr    (err_clr),
`ifdef UART_RX_PARITY_EN
        .parity_odd (parity_odd),
        .parity_err (parity_err),
`endif
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (rx_valid && !valid_prev) rise_cyc = cyc;
        valid_prev = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else begin
            n_pass++;
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Drives one frame bit-by-bit; optionally pulses rx_ready into the stop-sample
    // edge, or stops early (abort_at >= 0) leaving the line where it is.
    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_lvl,
                              input bit rdy_pulse, input int abort_at);
        logic [10:0] bits;
        bits    = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
        bits[9]  = par_bit;
        bits[10] = stop_lvl;
`else
        bits[9]  = stop_lvl;
        bits[10] = par_bit;
`endif
        @(posedge clk_in);
        #1;
        start_cyc = cyc;
        rise_cyc  = 0;
        for (int i = 0; i < NBITS * CPB; i++) begin
            if (i == abort_at) return;
            uart_rxd = bits[i / CPB];
            if (rdy_pulse) rx_ready = (i == STOP_SAMPLE - 1);
            tick(1);
        end
        uart_rxd = 1'b1;
        if (rdy_pulse) rx_ready = 1'b0;
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    initial begin
        sys_rstn = 1'b0;
        uart_rxd = 1'b1;
        rx_ready = 1'b0;
        err_clr  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
`endif
        #12;
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_data", rx_data, 8'h00);
        check("reset frame_err", frame_err, 0);
        check("reset overrun_err", overrun_err, 0);
        check("reset rx_busy", rx_busy, 0);
        tick(2);
        sys_rstn = 1'b1;
        tick(5);

        // Basic byte and handshake
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, -1);
        check("A5 valid latency", rise_cyc - start_cyc, STOP_SAMPLE);
        check("A5 rx_valid", rx_valid, 1);
        check("A5 rx_data", rx_data, 8'hA5);
        check("A5 frame_err", frame_err, 0);
        check("A5 rx_busy idle", rx_busy, 0);
        consume();
        check("A5 consumed", rx_valid, 0);

        // Short low glitch
        uart_rxd = 1'b0;
        tick(5);
        uart_rxd = 1'b1;
        check("glitch busy in START", rx_busy, 1);
        tick(20);
        check("glitch back to IDLE", rx_busy, 0);
        check("glitch rx_valid", rx_valid, 0);
        check("glitch frame_err", frame_err, 0);
        check("glitch overrun_err", overrun_err, 0);

        // Line held low from reset release
        sys_rstn = 1'b0;
        uart_rxd = 1'b0;
        tick(2);
        sys_rstn = 1'b1;
        tick(400);
        check("break frame_err", frame_err, 1);
        check("break busy", rx_busy, 1);
        check("break rx_valid", rx_valid, 0);
        pulse_clr();
        check("break err_clr", frame_err, 0);
        tick(400);
        check("break no repeat frame_err", frame_err, 0);
        check("break still busy", rx_busy, 1);
        uart_rxd = 1'b1;
        tick(5);
        check("break released", rx_busy, 0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, -1);
        check("3C rx_valid", rx_valid, 1);
        check("3C rx_data", rx_data, 8'h3C);
        consume();

        // Overrun: second byte lost while the first is unread
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, -1);
        check("overrun rx_data kept", rx_data, 8'h11);
        check("overrun rx_valid", rx_valid, 1);
        check("overrun flag", overrun_err, 1);
        consume();
        check("overrun consumed", rx_valid, 0);
        pulse_clr();
        check("overrun cleared", overrun_err, 0);

        // Same-cycle consume at the stop sample makes room for the new byte
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, -1);
        check("same-cycle rx_data", rx_data, 8'h22);
        check("same-cycle rx_valid", rx_valid, 1);
        check("same-cycle no overrun", overrun_err, 0);
        consume();

        // Reset in the middle of data bit 4
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 88);
        check("mid-frame busy", rx_busy, 1);
        sys_rstn = 1'b0;
        #1;
        check("mid reset rx_data", rx_data, 8'h00);
        check("mid reset rx_valid", rx_valid, 0);
        check("mid reset rx_busy", rx_busy, 0);
        check("mid reset frame_err", frame_err, 0);
        check("mid reset overrun_err", overrun_err, 0);
        uart_rxd = 1'b1;
        tick(3);
        sys_rstn = 1'b1;
        tick(5);
        send_frame(8'h7E, 1'b0, 1'b1, 1'b0, -1);
        check("7E rx_valid", rx_valid, 1);
        check("7E rx_data", rx_data, 8'h7E);
        check("7E frame_err", frame_err, 0);
        consume();

`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        send_frame(8'h03, 1'b1, 1'b1, 1'b0, -1);
        check("parity bad flag", parity_err, 1);
        check("parity bad dropped", rx_valid, 0);
        pulse_clr();
        check("parity cleared", parity_err, 0);
        send_frame(8'h03, 1'b0, 1'b1, 1'b0, -1);
        check("parity good valid", rx_valid, 1);
        check("parity good data", rx_data, 8'h03);
        check("parity good flag", parity_err, 0);
        consume();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
